// File: rtl/bus_arbiter.sv
// Two-master, three-slave bus controller: round-robin arbitration, one-hot slave decode,
// single valid pulse per transfer, ready wait with timeout, registered ack/err/rdata returns.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m1_req,
  input  logic        m1_mode,
  input  logic [15:0] m1_addr,
  input  logic [7:0]  m1_wdata,
  output logic [7:0]  m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  input  logic        m2_req,
  input  logic        m2_mode,
  input  logic [15:0] m2_addr,
  input  logic [7:0]  m2_wdata,
  output logic [7:0]  m2_rdata,
  output logic        m2_ack,
  output logic        m2_err,
  output logic        s_mode,
  output logic [15:0] s_addr,
  output logic [7:0]  s_wdata,
  output logic        s_valid,
  output logic [2:0]  s_sl,
  input  logic [7:0]  s_rdata0,
  input  logic [7:0]  s_rdata1,
  input  logic [7:0]  s_rdata2,
  input  logic [2:0]  s_ready
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;        // 0 = M1, 1 = M2
  logic        last_gnt_q, last_gnt_d;
  logic [7:0]  timer_q, timer_d;
  logic        mode_q, mode_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        valid_q, valid_d;
  logic [2:0]  sl_q, sl_d;
  logic [7:0]  m1_rdata_q, m1_rdata_d, m2_rdata_q, m2_rdata_d;
  logic        m1_ack_q, m1_ack_d, m2_ack_q, m2_ack_d;
  logic        m1_err_q, m1_err_d, m2_err_q, m2_err_d;

  logic        gnt_m2;
  logic        g_mode;
  logic [15:0] g_addr;
  logic [7:0]  g_wdata;
  logic [2:0]  g_sel;
  logic [7:0]  rdata_sel;
  logic        ready_sel;
  logic        done, fail, upd_rd;

  // M2 wins when it is the only requester, or on a tie when M1 was served last.
  assign gnt_m2  = m2_req & (~m1_req | ~last_gnt_q);
  assign g_mode  = gnt_m2 ? m2_mode  : m1_mode;
  assign g_addr  = gnt_m2 ? m2_addr  : m1_addr;
  assign g_wdata = gnt_m2 ? m2_wdata : m1_wdata;

  always_comb begin
    case (g_addr[12:11])
      2'b00:   g_sel = 3'b001;
      2'b01:   g_sel = 3'b010;
      2'b10:   g_sel = 3'b100;
      default: g_sel = 3'b000;
    endcase
  end

  always_comb begin
    case (sl_q)
      3'b001:  rdata_sel = s_rdata0;
      3'b010:  rdata_sel = s_rdata1;
      3'b100:  rdata_sel = s_rdata2;
      default: rdata_sel = 8'h00;
    endcase
  end

  assign ready_sel = |(s_ready & sl_q);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    timer_d    = timer_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    valid_d    = 1'b0;
    sl_d       = sl_q;
    done       = 1'b0;
    fail       = 1'b0;
    upd_rd     = 1'b0;
    case (state_q)
      StIdle: begin
        if (m1_req | m2_req) begin
          owner_d = gnt_m2;
          mode_d  = g_mode;
          addr_d  = g_addr;
          wdata_d = g_wdata;
          if (g_sel != 3'b000) begin
            sl_d    = g_sel;
            valid_d = 1'b1;
            state_d = StIssue;
          end else begin
            // Unmapped: complete with error without touching any slave.
            done    = 1'b1;
            fail    = 1'b1;
            state_d = StResp;
          end
        end
      end
      StIssue: begin
        timer_d = 8'd0;
        state_d = StWait;
      end
      StWait: begin
        if (ready_sel) begin
          done    = 1'b1;
          upd_rd  = ~mode_q;
          state_d = StResp;
        end else if (timer_q == TimeoutLast) begin
          done    = 1'b1;
          fail    = 1'b1;
          state_d = StResp;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      StResp: begin
        sl_d       = 3'b000;
        last_gnt_d = owner_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
    m1_ack_d   = done & ~owner_d;
    m2_ack_d   = done & owner_d;
    m1_err_d   = fail & ~owner_d;
    m2_err_d   = fail & owner_d;
    m1_rdata_d = (upd_rd & ~owner_d) ? rdata_sel : m1_rdata_q;
    m2_rdata_d = (upd_rd & owner_d)  ? rdata_sel : m2_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      timer_q    <= 8'd0;
      mode_q     <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 8'h00;
      valid_q    <= 1'b0;
      sl_q       <= 3'b000;
      m1_rdata_q <= 8'h00;
      m2_rdata_q <= 8'h00;
      m1_ack_q   <= 1'b0;
      m2_ack_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      m2_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      timer_q    <= timer_d;
      mode_q     <= mode_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      valid_q    <= valid_d;
      sl_q       <= sl_d;
      m1_rdata_q <= m1_rdata_d;
      m2_rdata_q <= m2_rdata_d;
      m1_ack_q   <= m1_ack_d;
      m2_ack_q   <= m2_ack_d;
      m1_err_q   <= m1_err_d;
      m2_err_q   <= m2_err_d;
    end
  end

  assign s_mode   = mode_q;
  assign s_addr   = addr_q;
  assign s_wdata  = wdata_q;
  assign s_valid  = valid_q;
  assign s_sl     = sl_q;
  assign m1_rdata = m1_rdata_q;
  assign m2_rdata = m2_rdata_q;
  assign m1_ack   = m1_ack_q;
  assign m2_ack   = m2_ack_q;
  assign m1_err   = m1_err_q;
  assign m2_err   = m2_err_q;

endmodule
